// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO instruction fetch front end.
package pio_pkg;

    localparam int unsigned PIO_ADDR_W = 4;
    localparam int unsigned PIO_DATA_W = 16;
    localparam int unsigned PIO_DEPTH  = 16;

    typedef logic [PIO_ADDR_W-1:0] pio_addr_t;
    typedef logic [PIO_DATA_W-1:0] pio_instr_t;

endpackage

// File: rtl/pio_instr_fetch_if.sv
// Host-side bundle for pio_instr_fetch: PC control, loader write port and read port.
interface pio_instr_fetch_if
    import pio_pkg::*;
#(
    parameter int unsigned ADDR_W = PIO_ADDR_W,
    parameter int unsigned DATA_W = PIO_DATA_W
) ();

    logic [ADDR_W-1:0] wrap_top;
    logic [ADDR_W-1:0] wrap_bottom;
    logic [ADDR_W-1:0] jump;
    logic              jump_en;
    logic              pc_en;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] write_addr;
    logic              write_en;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] data_out;

    modport master (
        output wrap_top, wrap_bottom, jump, jump_en, pc_en,
        output data_in, write_addr, write_en, read_addr,
        input  pc, data_out
    );

    modport slave (
        input  wrap_top, wrap_bottom, jump, jump_en, pc_en,
        input  data_in, write_addr, write_en, read_addr,
        output pc, data_out
    );

endinterface

// File: rtl/pio_pc.sv
// PIO program counter: jump, optional wrap window, modulo increment.
// Wrap support is compiled in only when PIO_WRAP_EN is defined.
module pio_pc
    import pio_pkg::*;
#(
    parameter int unsigned ADDR_W = PIO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wrap_top,
    input  logic [ADDR_W-1:0] wrap_bottom,
    input  logic [ADDR_W-1:0] jump,
    input  logic              jump_en,
    input  logic              pc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              at_top;

`ifdef PIO_WRAP_EN
    assign at_top = (pc_q == wrap_top);
`else
    // Wrap ports stay on the interface but carry no function in this build.
    logic unused_wrap;
    assign unused_wrap = ^{wrap_top, wrap_bottom};
    assign at_top      = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (jump_en) begin
            pc_d = jump;
        end else if (pc_en) begin
            if (at_top) begin
                pc_d = wrap_bottom;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/pio_instr_fetch.sv
// PIO instruction store (DEPTH x DATA_W, combinational read) plus program counter.
// Build option PIO_WRAP_EN enables the PC wrap window.
module pio_instr_fetch
    import pio_pkg::*;
#(
    parameter int unsigned ADDR_W = PIO_ADDR_W,
    parameter int unsigned DATA_W = PIO_DATA_W,
    parameter int unsigned DEPTH  = PIO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    pio_instr_fetch_if.slave  bus
);

    logic [DATA_W-1:0] mem [DEPTH];

    pio_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .wrap_top    (bus.wrap_top),
        .wrap_bottom (bus.wrap_bottom),
        .jump        (bus.jump),
        .jump_en     (bus.jump_en),
        .pc_en       (bus.pc_en),
        .pc          (bus.pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.write_en) begin
            mem[bus.write_addr] <= bus.data_in;
        end
    end

    // No bypass: a same-cycle write is seen only after the capturing edge.
    always_comb begin
        bus.data_out = mem[bus.read_addr];
    end

endmodule

// File: tb/tb_pio_instr_fetch.sv
// Directed self-checking bench for pio_instr_fetch (default and PIO_WRAP_EN builds).
module tb_pio_instr_fetch;
    import pio_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pio_instr_fetch_if bus ();

    pio_instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    int unsigned wrap_exp  [10];
    int unsigned past_exp  [13];
    int unsigned stick_exp [2];

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef PIO_WRAP_EN
        wrap_exp  = '{1, 2, 3, 4, 5, 2, 3, 4, 5, 2};
        past_exp  = '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 2};
        stick_exp = '{9, 9};
`else
        wrap_exp  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        past_exp  = '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5, 6};
        stick_exp = '{10, 11};
`endif
        rst             = 1'b0;
        bus.wrap_top    = '0;
        bus.wrap_bottom = '0;
        bus.jump        = '0;
        bus.jump_en     = 1'b0;
        bus.pc_en       = 1'b0;
        bus.data_in     = '0;
        bus.write_addr  = '0;
        bus.write_en    = 1'b0;
        bus.read_addr   = 4'd3;
        #3;
        check("reset_pc", 32'(bus.pc), 32'h0);
        check("reset_data", 32'(bus.data_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Write then read back at the same address.
        bus.write_en   = 1'b1;
        bus.write_addr = 4'd3;
        bus.data_in    = 16'hABCD;
        #1;
        check("wr_before_edge", 32'(bus.data_out), 32'h0000);
        step();
        bus.write_en = 1'b0;
        check("wr_after_edge", 32'(bus.data_out), 32'hABCD);
        check("wr_pc_idle", 32'(bus.pc), 32'h0);

        // Full-range count 0..15 -> 0 -> 1.
        bus.wrap_top    = 4'd15;
        bus.wrap_bottom = 4'd0;
        bus.pc_en       = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            check($sformatf("count_%0d", i), 32'(bus.pc), 32'(i % 16));
        end
        bus.pc_en = 1'b0;

        // Wrap window 2..5 from reset.
        pulse_reset();
        bus.wrap_top    = 4'd5;
        bus.wrap_bottom = 4'd2;
        check("wrap_start", 32'(bus.pc), 32'h0);
        bus.pc_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("wrap_%0d", i), 32'(bus.pc), 32'(wrap_exp[i]));
        end

        // Jump priority.
        bus.jump    = 4'd4;
        bus.jump_en = 1'b1;
        step();
        check("jump_to_4", 32'(bus.pc), 32'h4);
        bus.jump = 4'd9;
        step();
        check("jump_wins_pc_en", 32'(bus.pc), 32'h9);
        bus.jump    = 4'd4;
        step();
        bus.jump  = 4'd9;
        bus.pc_en = 1'b0;
        step();
        check("jump_no_pc_en", 32'(bus.pc), 32'h9);
        bus.jump_en = 1'b0;
        step();
        check("hold", 32'(bus.pc), 32'h9);

        // PC beyond wrap_top runs up through 15 -> 0 to reach it.
        bus.pc_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            check($sformatf("past_top_%0d", i), 32'(bus.pc), 32'(past_exp[i]));
        end

        // wrap_top == wrap_bottom sticks.
        bus.jump        = 4'd9;
        bus.jump_en     = 1'b1;
        step();
        bus.jump_en     = 1'b0;
        bus.wrap_top    = 4'd9;
        bus.wrap_bottom = 4'd9;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("stick_%0d", i), 32'(bus.pc), 32'(stick_exp[i]));
        end
        bus.pc_en = 1'b0;

        // Fill and sweep.
        bus.write_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.write_addr = 4'(a);
            bus.data_in    = 16'h1000 + 16'(a);
            step();
        end
        bus.write_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus.read_addr = 4'(a);
            #1;
            check($sformatf("sweep_%0d", a), 32'(bus.data_out), 32'h1000 + 32'(a));
        end
        bus.write_addr = 4'd5;
        bus.data_in    = 16'hFFFF;
        bus.read_addr  = 4'd5;
        step();
        check("no_write_when_off", 32'(bus.data_out), 32'h1005);

        // Asynchronous reset mid-run.
        bus.jump    = 4'd7;
        bus.jump_en = 1'b1;
        step();
        bus.jump_en = 1'b0;
        check("pre_rst_pc", 32'(bus.pc), 32'h7);
        check("pre_rst_data", 32'(bus.data_out), 32'h1005);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pc", 32'(bus.pc), 32'h0);
        check("async_rst_data", 32'(bus.data_out), 32'h0);
        bus.read_addr = 4'd15;
        #1;
        check("async_rst_data15", 32'(bus.data_out), 32'h0);
        bus.jump_en  = 1'b1;
        bus.pc_en    = 1'b1;
        bus.write_en = 1'b1;
        step();
        check("rst_overrides_pc", 32'(bus.pc), 32'h0);
        check("rst_overrides_wr", 32'(bus.data_out), 32'h0);
        bus.jump_en     = 1'b0;
        bus.write_en    = 1'b0;
        bus.wrap_top    = 4'd15;
        bus.wrap_bottom = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_pc1", 32'(bus.pc), 32'h1);
        step();
        check("post_rst_pc2", 32'(bus.pc), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
